strobe_seq_gen: RTL and testbench

- Parametrised successor to the fixed counter that pulses wr_en every 6 cycles in the core test harness.
- Generates one-cycle load/write strobes for NUM_CH channels with a programmable period. Channels map to ld_sp, ld_lr, ld_pc, ld_rd, ld_apsr, ld_ipsr and ild_primask.
- Supports periodic, one-shot and round-robin modes.
- Sits beside ControlUnit/Datapath and drives their strobe inputs for bring-up and directed test.

---
 rtl/strobe_seq_gen.sv | 199 +++++++++++++++++++
 tb/tb_strobe_seq_gen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/strobe_seq_gen.sv
// Programmable one-cycle strobe generator: periodic, one-shot and round-robin modes over NUM_CH channels.
// Optional build macro STROBE_GEN_STATS_EN adds a saturating strobe-cycle counter (strobe_total) with a stats_clr input.
module strobe_seq_gen #(
    parameter int NUM_CH   = 7,
    parameter int CNT_W    = 8,
    parameter int RR_PTR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  period,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              start,
    output logic [NUM_CH-1:0] strobe,
    output logic              wr_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  cnt
`ifdef STROBE_GEN_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [15:0]       strobe_total
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0]              MODE_PER = 2'd0;
    localparam logic [1:0]              MODE_ONE = 2'd1;
    localparam logic [1:0]              MODE_RR  = 2'd2;
    localparam int                      PW       = RR_PTR_W + 1;
    localparam logic [PW-1:0]           NUM_CH_W = PW'(NUM_CH);
    localparam logic [RR_PTR_W-1:0]     LAST_IDX = RR_PTR_W'(NUM_CH - 1);
    localparam logic [RR_PTR_W-1:0]     PTR_ONE  = RR_PTR_W'(1);
    localparam logic [NUM_CH-1:0]       ONE_CH   = NUM_CH'(1);
    localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     per_q, per_d;
    logic [1:0]           mode_q, mode_d;
    logic [RR_PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NUM_CH-1:0]    strobe_q, strobe_d;
    logic                 wr_en_q, wr_en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [1:0]           mode_eff;
    logic [CNT_W-1:0]     period_eff;
    logic                 terminal;
    logic                 rr_found;
    logic [NUM_CH-1:0]    rr_onehot;
    logic [RR_PTR_W-1:0]  rr_ptr_nxt;
    logic [PW-1:0]        probe;
    logic [RR_PTR_W-1:0]  probe_idx;

    assign mode_eff   = (mode == 2'd3) ? MODE_PER : mode;
    assign period_eff = (period == '0) ? CNT_ONE : period;
    assign terminal   = (cnt_q == per_q - CNT_ONE);

    // First set mask bit at or after rr_ptr_q, wrapping past the top channel.
    always_comb begin
        rr_found   = 1'b0;
        rr_onehot  = '0;
        rr_ptr_nxt = rr_ptr_q;
        probe      = '0;
        probe_idx  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            probe = {1'b0, rr_ptr_q} + PW'(k);
            if (probe >= NUM_CH_W) begin
                probe = probe - NUM_CH_W;
            end
            probe_idx = probe[RR_PTR_W-1:0];
            if (!rr_found && ch_mask[probe_idx]) begin
                rr_found   = 1'b1;
                rr_onehot  = ONE_CH << probe_idx;
                rr_ptr_nxt = (probe_idx == LAST_IDX) ? '0 : probe_idx + PTR_ONE;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        per_d    = per_q;
        mode_d   = mode_q;
        rr_ptr_d = rr_ptr_q;
        strobe_d = '0;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en && ((mode_eff != MODE_ONE) || start)) begin
                    state_d = RUN;
                    mode_d  = mode_eff;
                    per_d   = period_eff;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (terminal) begin
                    cnt_d = '0;
                    per_d = period_eff;
                    case (mode_q)
                        MODE_ONE: begin
                            strobe_d = ch_mask;
                            state_d  = DONE;
                        end
                        MODE_RR: begin
                            if (rr_found) begin
                                strobe_d = rr_onehot;
                                rr_ptr_d = rr_ptr_nxt;
                            end
                        end
                        default: strobe_d = ch_mask;
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
                // done lands the cycle after the one-shot strobe, unless en was dropped.
                done_d  = en;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign wr_en_d = |strobe_d;
    assign busy_d  = (state_d == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            per_q    <= '0;
            mode_q   <= MODE_PER;
            rr_ptr_q <= '0;
            strobe_q <= '0;
            wr_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            per_q    <= per_d;
            mode_q   <= mode_d;
            rr_ptr_q <= rr_ptr_d;
            strobe_q <= strobe_d;
            wr_en_q  <= wr_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign strobe = strobe_q;
    assign wr_en  = wr_en_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign cnt    = cnt_q;

`ifdef STROBE_GEN_STATS_EN
    logic [15:0] total_q, total_d;

    // Clear takes priority over a coincident strobe cycle.
    always_comb begin
        total_d = total_q;
        if (stats_clr) begin
            total_d = '0;
        end else if (wr_en_q && (total_q != 16'hFFFF)) begin
            total_d = total_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    assign strobe_total = total_q;
`endif

endmodule

// File: tb/tb_strobe_seq_gen.sv
// Randomized and directed bench for strobe_seq_gen against an interval-based reference model.
// Define STROBE_GEN_STATS_EN for both files to cover the strobe_total counter.
module tb_strobe_seq_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] period = 8'd0;
    logic [6:0] ch_mask = 7'd0;
    logic       start = 1'b0;
    logic [6:0] strobe;
    logic       wr_en;
    logic       busy;
    logic       done;
    logic [7:0] cnt;
`ifdef STROBE_GEN_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] strobe_total;
`endif

    int n_checks = 0;
    int n_errors = 0;

    strobe_seq_gen #(.NUM_CH(7), .CNT_W(8), .RR_PTR_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .period  (period),
        .ch_mask (ch_mask),
        .start   (start),
        .strobe  (strobe),
        .wr_en   (wr_en),
        .busy    (busy),
        .done    (done),
        .cnt     (cnt)
`ifdef STROBE_GEN_STATS_EN
        ,
        .stats_clr    (stats_clr),
        .strobe_total (strobe_total)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 = idle, 1 = running an interval, 2 = one-shot wrap-up.
    int         m_phase, m_elapsed, m_ivl, m_lmode, m_rr;
    logic [6:0] e_strobe;
    int         e_wr, e_busy, e_done, e_cnt, e_total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_elapsed = 0; m_ivl = 0; m_lmode = 0; m_rr = 0;
        e_strobe = '0; e_wr = 0; e_busy = 0; e_done = 0; e_cnt = 0; e_total = 0;
    endtask

    // Predict the outputs seen after the coming clock edge from the inputs applied now.
    task automatic model_step();
        int em, nd, old_wr, b;
        logic [6:0] ns;
        bit found;
        em = (mode == 2'd3) ? 0 : int'(mode);
        ns = '0; nd = 0; old_wr = e_wr; found = 0;
        case (m_phase)
            0: if (en && (em != 1 || start)) begin
                m_phase = 1; m_lmode = em; m_elapsed = 0;
                m_ivl = (period == 0) ? 1 : int'(period);
            end
            1: if (!en) begin
                m_phase = 0; m_elapsed = 0;
            end else if (m_elapsed + 1 >= m_ivl) begin
                m_elapsed = 0;
                m_ivl = (period == 0) ? 1 : int'(period);
                if (m_lmode == 2) begin
                    for (int k = 0; k < 7; k++) begin
                        b = (m_rr + k) % 7;
                        if (!found && ch_mask[b]) begin
                            found = 1; ns[b] = 1'b1; m_rr = (b + 1) % 7;
                        end
                    end
                end else begin
                    ns = ch_mask;
                    if (m_lmode == 1) m_phase = 2;
                end
            end else begin
                m_elapsed++;
            end
            default: begin
                nd = en ? 1 : 0; m_phase = 0;
            end
        endcase
        e_strobe = ns;
        e_wr     = (ns != 0) ? 1 : 0;
        e_busy   = (m_phase == 1) ? 1 : 0;
        e_done   = nd;
        e_cnt    = (m_phase == 1) ? m_elapsed : 0;
`ifdef STROBE_GEN_STATS_EN
        if (stats_clr) e_total = 0;
        else if (old_wr != 0 && e_total < 65535) e_total++;
`endif
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("strobe", 32'(strobe), 32'(e_strobe));
        chk("wr_en", 32'(wr_en), e_wr);
        chk("busy", 32'(busy), e_busy);
        chk("done", 32'(done), e_done);
        chk("cnt", 32'(cnt), e_cnt);
`ifdef STROBE_GEN_STATS_EN
        chk("total", 32'(strobe_total), e_total);
`endif
        if (wr_en || done)
            $display("txn t=%0t strobe=%02h done=%0d cnt=%0d", $time, strobe, done, cnt);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_strobe"}, 32'(strobe), 32'd0);
        chk({tag, "_wr"}, 32'(wr_en), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_cnt"}, 32'(cnt), 32'd0);
    endtask

    task automatic do_reset();
        en = 0; start = 0; mode = 0; period = 0; ch_mask = 0;
`ifdef STROBE_GEN_STATS_EN
        stats_clr = 0;
`endif
        rst = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst");
`ifdef STROBE_GEN_STATS_EN
        chk("rst_total", 32'(strobe_total), 32'd0);
`endif
        rst = 1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, cyc, sc, dc;
        logic [6:0] rr_seen[4];
        logic [6:0] rr_exp[4];
        rr_exp[0] = 7'h01; rr_exp[1] = 7'h04; rr_exp[2] = 7'h20; rr_exp[3] = 7'h01;

        // Periodic, period 6: strobes at cycles 7, 13, 19.
        do_reset();
        mode = 0; period = 8'd6; ch_mask = 7'h7F; en = 1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            chk("per_wr", 32'(wr_en), (c == 7 || c == 13 || c == 19) ? 32'd1 : 32'd0);
            chk("per_cnt", 32'(cnt), 32'((c - 1) % 6));
        end

        // Period 0 acts as 1: strobe every cycle from the second RUN cycle.
        do_reset();
        mode = 0; period = 8'd0; ch_mask = 7'h01; en = 1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk("p0_strobe", 32'(strobe), (c >= 2) ? 32'd1 : 32'd0);
        end

        // Round-robin over mask 0100101, then empty mask, then full mask.
        do_reset();
        mode = 2; period = 8'd2; ch_mask = 7'b0100101; en = 1;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            tick();
            if (wr_en) begin rr_seen[got] = strobe; got++; end
        end
        chk("rr_count", got, 4);
        for (int i = 0; i < got; i++) chk("rr_seq", 32'(rr_seen[i]), 32'(rr_exp[i]));
        ch_mask = 7'h00;
        got = 0;
        for (int c = 0; c < 10; c++) begin tick(); if (wr_en) got++; end
        chk("rr_empty", got, 0);
        ch_mask = 7'h7F;
        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            tick();
            if (wr_en) begin got = 1; chk("rr_resume", 32'(strobe), 32'h02); end
        end
        chk("rr_resume_seen", got, 1);

        // One-shot, period 4, with a second start while busy.
        do_reset();
        mode = 1; period = 8'd4; ch_mask = 7'h10; en = 1; start = 1;
        got = 0; sc = 0; dc = 0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            start = (c == 2) ? 1'b1 : 1'b0;
            if (wr_en) begin got++; sc = c; chk("os_strobe", 32'(strobe), 32'h10); end
            if (done) dc = c;
            if (c == 4) chk("os_busy4", 32'(busy), 32'd1);
            if (c == 5) chk("os_busy5", 32'(busy), 32'd0);
        end
        chk("os_count", got, 1);
        chk("os_strobe_cyc", sc, 5);
        chk("os_done_cyc", dc, 6);

        // Asynchronous reset at cnt = 3, then a full period + 1 to the first strobe.
        do_reset();
        mode = 0; period = 8'd6; ch_mask = 7'h7F; en = 1;
        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin tick(); if (cnt == 8'd3) got = 1; end
        chk("rst_cnt3_seen", got, 1);
        #2 rst = 0;
        #1 check_zero("arst");
        model_reset();
        rst = 1;
        cyc = 0;
        for (int c = 1; c <= 12 && cyc == 0; c++) begin tick(); if (wr_en) cyc = c; end
        chk("arst_first", cyc, 7);

        // Asynchronous reset while a strobe is high.
        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin tick(); if (wr_en) got = 1; end
        #2 rst = 0;
        #1 check_zero("arst_hi");
        model_reset();
        rst = 1;
        tick();

`ifdef STROBE_GEN_STATS_EN
        do_reset();
        mode = 0; period = 8'd0; ch_mask = 7'h01; en = 1;
        got = 0;
        for (int c = 0; c < 30 && got < 10; c++) begin tick(); if (wr_en) got++; end
        en = 0;
        tick(); tick();
        chk("stats_10", 32'(strobe_total), 32'd10);
        en = 1;
        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin tick(); if (wr_en) got = 1; end
        stats_clr = 1; en = 0;
        tick();
        chk("stats_clr", 32'(strobe_total), 32'd0);
        stats_clr = 0;
        tick();
`endif

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
            period  = 8'($urandom_range(0, 5));
            ch_mask = ($urandom_range(0, 7) == 0) ? 7'h00 : 7'($urandom);
            start   = ($urandom_range(0, 3) == 0);
`ifdef STROBE_GEN_STATS_EN
            stats_clr = ($urandom_range(0, 19) == 0);
`endif
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
